// File: rtl/debug_unit_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared constants and types for the MIPS debug unit:
//   - host command bytes
//   - state encoding shared by the control FSM and the byte serializer
//   - dump frame layout (section lengths, total byte count)
//   - pipeline reset pulse length
//   - default bus widths used by the interface and the top
// -----------------------------------------------------------------------------
package debug_pkg;

    // Default widths
    localparam int NB_REG_DEF       = 32;
    localparam int NB_REG_ADDR_DEF  = 5;
    localparam int NB_DATA_ADDR_DEF = 10;
    localparam int NB_BYTE_DEF      = 8;

    // Host command bytes
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
    localparam logic [7:0] CMD_RST  = 8'h58;  // 'X'

    // IDLE/SEND/ACK/WAIT are also reused by the word serializer.
    // In the control FSM, SEND means "a word is in flight in the serializer".
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        PRST,
        LOAD,
        SEND,
        ACK,
        WAIT
    } state_t;

    // Dump frame layout: PC, cycle count, register file, data-memory window
    localparam int HDR_WORDS      = 2;
    localparam int RF_WORDS       = 32;
    localparam int DM_WORDS       = 32;
    localparam int BYTES_PER_WORD = 4;

    function automatic int frame_bytes(input int rf_words, input int dm_words);
        return BYTES_PER_WORD * (HDR_WORDS + rf_words + dm_words);
    endfunction

    localparam int FRAME_BYTES = frame_bytes(RF_WORDS, DM_WORDS);

    // Pipeline reset pulse length, in clock cycles
    localparam int PRST_CYCLES = 2;

endpackage

// File: rtl/debug_unit_if.sv
// -----------------------------------------------------------------------------
// debug_unit_if
// Bundles the UART RX/TX handshake and the pipeline control/readout bus of
// the debug unit. Names keep the debug unit's point of view (i_ = into the
// debug unit, o_ = out of it).
//   master : debug unit side
//   slave  : UART + pipeline side (the testbench in simulation)
// Signals:
//   i_rx_data/i_rx_valid   received byte + one-cycle valid pulse
//   o_tx_data/o_tx_start   byte to transmit + one-cycle start request
//   i_tx_busy              transmitter busy
//   o_pipe_valid           pipeline advance enable
//   o_pipe_reset           pipeline reset, active-low
//   i_halt, i_pc           halt retired flag, current PC
//   o_rf_addr/i_rf_data    register-file debug read port
//   o_dm_addr/i_dm_data    data-memory debug read port
// -----------------------------------------------------------------------------
interface debug_unit_if
    import debug_pkg::*;
#(
    parameter int NB_REG       = NB_REG_DEF,
    parameter int NB_REG_ADDR  = NB_REG_ADDR_DEF,
    parameter int NB_DATA_ADDR = NB_DATA_ADDR_DEF,
    parameter int NB_BYTE      = NB_BYTE_DEF
);
    logic [NB_BYTE-1:0]      i_rx_data;
    logic                    i_rx_valid;
    logic [NB_BYTE-1:0]      o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_busy;
    logic                    o_pipe_valid;
    logic                    o_pipe_reset;
    logic                    i_halt;
    logic [NB_REG-1:0]       i_pc;
    logic [NB_REG_ADDR-1:0]  o_rf_addr;
    logic [NB_REG-1:0]       i_rf_data;
    logic [NB_DATA_ADDR-1:0] o_dm_addr;
    logic [NB_REG-1:0]       i_dm_data;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_halt, i_pc, i_rf_data, i_dm_data,
        output o_tx_data, o_tx_start, o_pipe_valid, o_pipe_reset, o_rf_addr, o_dm_addr
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_busy, i_halt, i_pc, i_rf_data, i_dm_data,
        input  o_tx_data, o_tx_start, o_pipe_valid, o_pipe_reset, o_rf_addr, o_dm_addr
    );
endinterface

// File: rtl/debug_unit_word_serializer.sv
// -----------------------------------------------------------------------------
// debug_word_serializer
// Sends one word to a UART transmitter as bytes, MSB first.
// Ports:
//   i_clock, i_reset  clock, asynchronous active-low reset
//   i_load, i_word    load a word and start sending (accepted only when idle)
//   i_tx_busy         transmitter busy
//   o_tx_start        one-cycle transmit request (never while busy)
//   o_tx_data         byte being requested (top byte of the shift register)
//   o_word_done       one-cycle pulse once the last byte of the word has
//                     been accepted and the transmitter is free again
// -----------------------------------------------------------------------------
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_tx_busy,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_word_done
);
    localparam int NB_BYTES = NB_WORD / NB_BYTE;
    localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE   = NB_CNT'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [NB_WORD-1:0]  r_shift;
    logic [NB_WORD-1:0]  w_shift_next;
    logic [NB_CNT-1:0]   r_byte_cnt;
    logic [NB_CNT-1:0]   w_byte_cnt_next;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_byte_cnt <= w_byte_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_byte_cnt_next = r_byte_cnt;
        o_tx_start      = 1'b0;
        o_word_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_shift_next    = i_word;
                    w_byte_cnt_next = '0;
                    w_state_next    = SEND;
                end
            end
            // Start is qualified by the live busy input so it can never
            // coincide with a busy transmitter.
            SEND: begin
                if (!i_tx_busy) begin
                    o_tx_start   = 1'b1;
                    w_state_next = ACK;
                end
            end
            ACK: begin
                if (i_tx_busy) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (!i_tx_busy) begin
                    w_shift_next = r_shift << NB_BYTE;
                    if (r_byte_cnt == LAST_BYTE) begin
                        o_word_done     = 1'b1;
                        w_byte_cnt_next = '0;
                        w_state_next    = IDLE;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + CNT_ONE;
                        w_state_next    = SEND;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_tx_data = r_shift[NB_WORD-1 -: NB_BYTE];

endmodule

// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
// Host-side control and readout end of the MIPS pipeline.
//   - Decodes host command bytes in IDLE: R (run to halt), S (single step),
//     D (dump), X (pulse pipeline reset). Bytes outside IDLE are dropped.
//   - Gates the pipeline advance enable and counts advanced cycles
//     (saturating, cleared only by the pipeline-reset command or reset).
//   - Dumps PC, cycle count, R0..Rn and DM[0..m] as bytes, MSB first.
// Ports:
//   i_clock  system clock (same as the pipeline)
//   i_reset  asynchronous, active-low reset
//   bus      debug_unit_if.master: UART RX/TX handshake and pipeline bus
// -----------------------------------------------------------------------------
module debug_unit
    import debug_pkg::*;
#(
    parameter int NB_REG          = NB_REG_DEF,
    parameter int NB_REG_ADDR     = NB_REG_ADDR_DEF,
    parameter int REGFILE_DEPTH   = RF_WORDS,
    parameter int NB_DATA_ADDR    = NB_DATA_ADDR_DEF,
    parameter int DATA_DUMP_WORDS = DM_WORDS,
    parameter int NB_BYTE         = NB_BYTE_DEF
) (
    input  logic         i_clock,
    input  logic         i_reset,
    debug_unit_if.master bus
);
    // Word index within a dump frame: 0 = PC, 1 = count, then RF, then DM
    localparam int NB_IDX = 16;
    localparam logic [NB_IDX-1:0] IDX_PC       = '0;
    localparam logic [NB_IDX-1:0] IDX_RF_FIRST = NB_IDX'(HDR_WORDS);
    localparam logic [NB_IDX-1:0] IDX_RF_LAST  = NB_IDX'(HDR_WORDS + REGFILE_DEPTH - 1);
    localparam logic [NB_IDX-1:0] IDX_DM_FIRST = NB_IDX'(HDR_WORDS + REGFILE_DEPTH);
    localparam logic [NB_IDX-1:0] IDX_LAST     = NB_IDX'(HDR_WORDS + REGFILE_DEPTH + DATA_DUMP_WORDS - 1);
    localparam logic [NB_IDX-1:0] IDX_ONE      = NB_IDX'(1);
    localparam logic [1:0]        PRST_LAST    = 2'(PRST_CYCLES - 1);
    localparam logic [NB_REG_ADDR-1:0]  RF_ONE = NB_REG_ADDR'(1);
    localparam logic [NB_DATA_ADDR-1:0] DM_ONE = NB_DATA_ADDR'(1);
    localparam logic [NB_REG-1:0]       CNT_ONE = NB_REG'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NB_IDX-1:0]       r_word_idx;
    logic                    r_settle;
    logic [1:0]              r_prst_cnt;
    logic [NB_REG-1:0]       r_cycle_cnt;
    logic [NB_REG-1:0]       r_cnt_snap;
    logic [NB_REG_ADDR-1:0]  r_rf_addr;
    logic [NB_DATA_ADDR-1:0] r_dm_addr;

    logic                    w_pipe_valid;
    logic                    w_pipe_reset;
    logic                    w_ser_load;
    logic                    w_word_done;
    logic [NB_REG-1:0]       w_word;

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and FSM outputs
    always_comb begin
        w_state_next = r_state;
        w_pipe_valid = 1'b0;
        w_pipe_reset = 1'b1;
        w_ser_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    case (bus.i_rx_data)
                        CMD_RUN:  w_state_next = RUN;
                        CMD_STEP: w_state_next = STEP;
                        CMD_DUMP: w_state_next = LOAD;
                        CMD_RST:  w_state_next = PRST;
                        default:  w_state_next = IDLE;
                    endcase
                end
            end
            RUN: begin
                w_pipe_valid = !bus.i_halt;
                if (bus.i_halt) begin
                    w_state_next = LOAD;
                end
            end
            STEP: begin
                w_pipe_valid = !bus.i_halt;
                w_state_next = LOAD;
            end
            PRST: begin
                w_pipe_reset = 1'b0;
                if (r_prst_cnt == PRST_LAST) begin
                    w_state_next = IDLE;
                end
            end
            // First LOAD cycle lets the read address settle, second hands
            // the word to the serializer.
            LOAD: begin
                if (r_settle) begin
                    w_ser_load   = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_word_done) begin
                    w_state_next = (r_word_idx == IDX_LAST) ? IDLE : LOAD;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Frame word selection. PC is taken live on the frame's first load (the
    // pipeline is frozen from here on); the count uses the copy taken then.
    always_comb begin
        w_word = bus.i_dm_data;
        if (r_word_idx == IDX_PC) begin
            w_word = bus.i_pc;
        end else if (r_word_idx < IDX_RF_FIRST) begin
            w_word = r_cnt_snap;
        end else if (r_word_idx <= IDX_RF_LAST) begin
            w_word = bus.i_rf_data;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_word_idx  <= '0;
            r_settle    <= 1'b0;
            r_prst_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_cnt_snap  <= '0;
            r_rf_addr   <= '0;
            r_dm_addr   <= '0;
        end else begin
            r_settle   <= (r_state == LOAD) && !r_settle;
            r_prst_cnt <= (r_state == PRST) ? r_prst_cnt + 2'd1 : 2'd0;

            if (r_state == PRST) begin
                r_cycle_cnt <= '0;
            end else if (w_pipe_valid && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            end

            if ((r_state == LOAD) && r_settle && (r_word_idx == IDX_PC)) begin
                r_cnt_snap <= r_cycle_cnt;
            end

            // Advance to the next word's read address once the current word
            // is fully sent; addresses hold at their last value and only
            // return to 0 when the frame ends.
            if (w_word_done) begin
                if (r_word_idx == IDX_LAST) begin
                    r_word_idx <= '0;
                    r_rf_addr  <= '0;
                    r_dm_addr  <= '0;
                end else begin
                    r_word_idx <= r_word_idx + IDX_ONE;
                    if ((r_word_idx >= IDX_RF_FIRST) && (r_word_idx < IDX_RF_LAST)) begin
                        r_rf_addr <= r_rf_addr + RF_ONE;
                    end else if (r_word_idx >= IDX_DM_FIRST) begin
                        r_dm_addr <= r_dm_addr + DM_ONE;
                    end
                end
            end
        end
    end

    debug_word_serializer #(
        .NB_WORD (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (w_ser_load),
        .i_word      (w_word),
        .i_tx_busy   (bus.i_tx_busy),
        .o_tx_start  (bus.o_tx_start),
        .o_tx_data   (bus.o_tx_data),
        .o_word_done (w_word_done)
    );

    assign bus.o_pipe_valid = w_pipe_valid;
    assign bus.o_pipe_reset = w_pipe_reset;
    assign bus.o_rf_addr    = r_rf_addr;
    assign bus.o_dm_addr    = r_dm_addr;

endmodule

// File: tb/tb_debug_unit.sv
// -----------------------------------------------------------------------------
// tb_debug_unit
// Directed bench for debug_unit: models the UART TX (busy for a programmable
// number of cycles per byte), the register file and the data memory, and
// checks each dump frame byte-by-byte against hand-computed layouts.
// -----------------------------------------------------------------------------
module tb_debug_unit;
    localparam int FRAME = 264;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    debug_unit_if bus ();

    debug_unit dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rf_mem [32];
    logic [31:0] dm_mem [32];
    assign bus.i_rf_data = rf_mem[bus.o_rf_addr];
    assign bus.i_dm_data = dm_mem[bus.o_dm_addr];

    int checks   = 0;
    int failures = 0;
    int busy_cycles = 2;
    logic [7:0] tx_q [$];
    int pv_cnt      = 0;
    int prst_lo_cnt = 0;
    int busy_viol   = 0;

    // UART TX model: accept a start, go busy next cycle for busy_cycles cycles
    initial begin
        bus.i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start === 1'b1) begin
                tx_q.push_back(bus.o_tx_data);
                @(posedge clk);
                #1 bus.i_tx_busy = 1'b1;
                repeat (busy_cycles) @(posedge clk);
                #1 bus.i_tx_busy = 1'b0;
            end
        end
    end

    // Activity counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_pipe_valid === 1'b1) pv_cnt++;
        if (bus.o_pipe_reset === 1'b0) prst_lo_cnt++;
        if (bus.o_tx_start === 1'b1 && bus.i_tx_busy === 1'b1) busy_viol++;
    end

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pc, input logic [31:0] cnt);
        int w;
        int sh;
        logic [31:0] word;
        w  = k / 4;
        sh = (3 - (k % 4)) * 8;
        if (w == 0)       word = pc;
        else if (w == 1)  word = cnt;
        else if (w < 34)  word = rf_mem[w - 2];
        else              word = dm_mem[w - 34];
        return 8'(word >> sh);
    endfunction

    function automatic int frame_errors(input int base, input logic [31:0] pc,
                                        input logic [31:0] cnt, output int first);
        int e;
        e = 0;
        first = -1;
        for (int k = 0; k < FRAME; k++) begin
            if ((base + k >= tx_q.size()) || (tx_q[base + k] !== exp_byte(k, pc, cnt))) begin
                e++;
                if (first < 0) first = k;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] got_word(input int b);
        if (b + 4 > tx_q.size()) return 32'hxxxxxxxx;
        return {tx_q[b], tx_q[b + 1], tx_q[b + 2], tx_q[b + 3]};
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1 bus.i_rx_data = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_frame(input int base, output bit ok);
        int n;
        int limit;
        n = 0;
        limit = FRAME * (busy_cycles + 6) + 500;
        while (tx_q.size() < base + FRAME && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (tx_q.size() >= base + FRAME);
        repeat (busy_cycles + 10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_halt     = 1'b0;
        bus.i_pc       = 32'h0000_0040;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%0b exp=0", bus.o_tx_start); end
        checks++; if (bus.o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%02h exp=00", bus.o_tx_data); end
        checks++; if (bus.o_pipe_valid !== 1'b0) begin failures++; $display("FAIL reset_pipe_valid got=%0b exp=0", bus.o_pipe_valid); end
        checks++; if (bus.o_pipe_reset !== 1'b1) begin failures++; $display("FAIL reset_pipe_reset got=%0b exp=1", bus.o_pipe_reset); end
        checks++; if (bus.o_rf_addr !== 5'd0) begin failures++; $display("FAIL reset_rf_addr got=%0d exp=0", bus.o_rf_addr); end
        checks++; if (bus.o_dm_addr !== 10'd0) begin failures++; $display("FAIL reset_dm_addr got=%0d exp=0", bus.o_dm_addr); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: released");
    endtask

    task automatic test_dump();
        int base, pv0, errs, fb;
        bit ok;
        logic [63:0] got8;
        base = tx_q.size();
        pv0  = pv_cnt;
        bus.i_pc = 32'h0000_0040;
        send_cmd(8'h44);
        wait_frame(base, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dump_len got=%0d exp=%0d", tx_q.size() - base, FRAME); end
        got8 = {got_word(base), got_word(base + 4)};
        checks++; if (got8 !== 64'h0000_0040_0000_0000) begin failures++; $display("FAIL dump_first8 got=%016h exp=0000004000000000", got8); end
        errs = frame_errors(base, 32'h40, 32'h0, fb);
        checks++; if (errs !== 0) begin failures++; $display("FAIL dump_frame bad_bytes=%0d first_bad=%0d exp=0", errs, fb); end
        checks++; if (pv_cnt - pv0 !== 0) begin failures++; $display("FAIL dump_pipe_valid got=%0d exp=0", pv_cnt - pv0); end
        checks++; if (bus.o_rf_addr !== 5'd0 || bus.o_dm_addr !== 10'd0) begin failures++; $display("FAIL dump_addr_end got=%0d/%0d exp=0/0", bus.o_rf_addr, bus.o_dm_addr); end
        $display("dump: %0d bytes, pc=%08h cnt=%08h", tx_q.size() - base, got_word(base), got_word(base + 4));
    endtask

    task automatic test_step();
        int base, pv0, errs, fb;
        bit ok;
        for (int s = 1; s <= 3; s++) begin
            base = tx_q.size();
            pv0  = pv_cnt;
            bus.i_pc = 32'h0000_0040 + 32'(4 * s);
            send_cmd(8'h53);
            wait_frame(base, ok);
            checks++; if (pv_cnt - pv0 !== 1) begin failures++; $display("FAIL step%0d_pipe_valid got=%0d exp=1", s, pv_cnt - pv0); end
            checks++; if (got_word(base + 4) !== 32'(s)) begin failures++; $display("FAIL step%0d_count got=%08h exp=%08h", s, got_word(base + 4), 32'(s)); end
            errs = frame_errors(base, bus.i_pc, 32'(s), fb);
            checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL step%0d_frame bad_bytes=%0d first_bad=%0d exp=0", s, errs, fb); end
            $display("step %0d: pc=%08h cnt=%08h", s, got_word(base), got_word(base + 4));
        end
    endtask

    task automatic test_prst();
        int base, pv0, pr0, errs, fb;
        bit ok;
        base = tx_q.size();
        pv0  = pv_cnt;
        pr0  = prst_lo_cnt;
        send_cmd(8'h58);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (prst_lo_cnt - pr0 !== 2) begin failures++; $display("FAIL prst_low_cycles got=%0d exp=2", prst_lo_cnt - pr0); end
        checks++; if (tx_q.size() !== base) begin failures++; $display("FAIL prst_tx_bytes got=%0d exp=0", tx_q.size() - base); end
        send_cmd(8'h00);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (tx_q.size() !== base || pv_cnt !== pv0 || prst_lo_cnt - pr0 !== 2) begin
            failures++; $display("FAIL null_cmd_activity got=tx%0d/pv%0d/prst%0d exp=0/0/2", tx_q.size() - base, pv_cnt - pv0, prst_lo_cnt - pr0);
        end
        send_cmd(8'h44);
        wait_frame(base, ok);
        checks++; if (got_word(base + 4) !== 32'h0) begin failures++; $display("FAIL prst_count got=%08h exp=00000000", got_word(base + 4)); end
        errs = frame_errors(base, bus.i_pc, 32'h0, fb);
        checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL prst_frame bad_bytes=%0d first_bad=%0d exp=0", errs, fb); end
        $display("prst: low=%0d cycles, next dump cnt=%08h", prst_lo_cnt - pr0, got_word(base + 4));
    endtask

    task automatic test_run();
        int base, pv0, errs, fb;
        bit ok;
        base = tx_q.size();
        pv0  = pv_cnt;
        bus.i_pc = 32'h0000_0100;
        send_cmd(8'h52);
        repeat (10) @(posedge clk);
        #1 bus.i_halt = 1'b1;
        bus.i_pc = 32'h0000_0124;
        wait_frame(base, ok);
        checks++; if (pv_cnt - pv0 !== 10) begin failures++; $display("FAIL run_pipe_valid got=%0d exp=10", pv_cnt - pv0); end
        checks++; if (got_word(base + 4) !== 32'h0000_000A) begin failures++; $display("FAIL run_count got=%08h exp=0000000a", got_word(base + 4)); end
        checks++; if (got_word(base) !== 32'h0000_0124) begin failures++; $display("FAIL run_pc got=%08h exp=00000124", got_word(base)); end
        errs = frame_errors(base, 32'h124, 32'hA, fb);
        checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL run_frame bad_bytes=%0d first_bad=%0d exp=0", errs, fb); end
        $display("run: valid=%0d cycles, pc=%08h cnt=%08h", pv_cnt - pv0, got_word(base), got_word(base + 4));

        // Run requested with halt already high: no advance, straight to dump
        base = tx_q.size();
        pv0  = pv_cnt;
        send_cmd(8'h52);
        wait_frame(base, ok);
        checks++; if (pv_cnt - pv0 !== 0) begin failures++; $display("FAIL run_halted_pipe_valid got=%0d exp=0", pv_cnt - pv0); end
        errs = frame_errors(base, 32'h124, 32'hA, fb);
        checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL run_halted_frame bad_bytes=%0d first_bad=%0d exp=0", errs, fb); end
        $display("run halted: valid=%0d cycles, cnt=%08h", pv_cnt - pv0, got_word(base + 4));
        bus.i_halt = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base, pv0, pr0, bv0, errs, fb;
        bit ok;
        logic [7:0] inj [4];
        inj[0] = 8'h44; inj[1] = 8'h52; inj[2] = 8'h58; inj[3] = 8'h44;
        busy_cycles = 50;
        base = tx_q.size();
        pv0  = pv_cnt;
        pr0  = prst_lo_cnt;
        bv0  = busy_viol;
        send_cmd(8'h44);
        for (int i = 0; i < 4; i++) begin
            repeat (400) @(posedge clk);
            send_cmd(inj[i]);
        end
        wait_frame(base, ok);
        errs = frame_errors(base, 32'h124, 32'hA, fb);
        checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL bp_frame bad_bytes=%0d first_bad=%0d exp=0", errs, fb); end
        checks++; if (busy_viol !== bv0) begin failures++; $display("FAIL bp_start_while_busy got=%0d exp=0", busy_viol - bv0); end
        checks++; if (pv_cnt !== pv0 || prst_lo_cnt !== pr0) begin failures++; $display("FAIL bp_injected_cmds got=pv%0d/prst%0d exp=0/0", pv_cnt - pv0, prst_lo_cnt - pr0); end
        repeat (200) @(posedge clk);
        #1;
        checks++; if (tx_q.size() !== base + FRAME) begin failures++; $display("FAIL bp_extra_bytes got=%0d exp=%0d", tx_q.size() - base, FRAME); end
        $display("backpressure: %0d bytes, busy=%0d cycles/byte", tx_q.size() - base, busy_cycles);
        busy_cycles = 2;
    endtask

    task automatic test_reset_mid_dump();
        int base, n, errs, fb;
        bit ok;
        base = tx_q.size();
        send_cmd(8'h44);
        n = 0;
        while (tx_q.size() < base + 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (tx_q.size() < base + 100) begin failures++; $display("FAIL rstmid_reach100 got=%0d exp=100", tx_q.size() - base); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx got=%0b/%02h exp=0/00", bus.o_tx_start, bus.o_tx_data); end
        checks++; if (bus.o_pipe_valid !== 1'b0 || bus.o_pipe_reset !== 1'b1) begin failures++; $display("FAIL rstmid_pipe got=%0b/%0b exp=0/1", bus.o_pipe_valid, bus.o_pipe_reset); end
        checks++; if (bus.o_rf_addr !== 5'd0 || bus.o_dm_addr !== 10'd0) begin failures++; $display("FAIL rstmid_addr got=%0d/%0d exp=0/0", bus.o_rf_addr, bus.o_dm_addr); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (tx_q.size() !== base + 100) begin failures++; $display("FAIL rstmid_no_resume got=%0d exp=100", tx_q.size() - base); end
        base = tx_q.size();
        send_cmd(8'h44);
        wait_frame(base, ok);
        errs = frame_errors(base, 32'h124, 32'h0, fb);
        checks++; if (!ok || errs !== 0) begin failures++; $display("FAIL rstmid_frame bad_bytes=%0d first_bad=%0d exp=0", errs, fb); end
        $display("reset mid-dump: new frame %0d bytes, first=%02h", tx_q.size() - base, (tx_q.size() > base) ? tx_q[base] : 8'hxx);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
            dm_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0102_0304);
        end
        test_reset();
        test_dump();
        test_step();
        test_prst();
        test_run();
        test_back_to_back();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
